// File: rtl/uram_readback_checker_pkg.sv
// ------------------------------------------------------------------------
// uram_chk_pkg: shared types, default geometry and expected-pattern helper.
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package uram_chk_pkg;

  localparam int          DEF_ADDR_W = 12;
  localparam int          DEF_DATA_W = 64;
  localparam logic [11:0] DEF_OFFSET = 12'h10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Pattern is (addr + offset) wrapped to the address width, zero-extended.
  function automatic logic [63:0] expected_word(input logic [31:0] addr,
                                                input logic [31:0] offset,
                                                input int unsigned aw);
    logic [31:0] sum;
    logic [31:0] mask;
    sum  = addr + offset;
    mask = (aw >= 32) ? '1 : ((32'd1 << aw) - 32'd1);
    return {32'd0, sum & mask};
  endfunction

endpackage

`default_nettype wire

// File: rtl/uram_readback_checker_if.sv
// ------------------------------------------------------------------------
// uram_chk_mem_if: read-side URAM bus between checker (master) and memory.
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface uram_chk_mem_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, output mem_ren, input  mem_rdata);
  modport slave  (input  mem_addr, input  mem_ren, output mem_rdata);
endinterface

`default_nettype wire

// File: rtl/uram_readback_checker_tag_pipe.sv
// ------------------------------------------------------------------------
// uram_chk_tag_pipe: RD_LAT-deep {valid, addr} delay line, cleared by reset.
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module uram_chk_tag_pipe
  import uram_chk_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              pending_o
);

  logic [RD_LAT-1:0] valid_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      addr_q[0]  <= addr_i;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[RD_LAT-1];
  assign addr_o  = addr_q[RD_LAT-1];

  // Entries still in flight behind the output stage.
  if (RD_LAT > 1) begin : g_pend
    assign pending_o = |valid_q[RD_LAT-2:0];
  end else begin : g_nopend
    assign pending_o = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/uram_readback_checker.sv
// ------------------------------------------------------------------------
// uram_readback_checker: sweeps a URAM with reads, checks addr+OFFSET pattern.
// Option URAM_CHK_STOP_ON_ERR_EN stops issuing on first mismatch. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module uram_readback_checker
  import uram_chk_pkg::*;
#(
  parameter int                ADDR_W = DEF_ADDR_W,
  parameter int                DATA_W = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] OFFSET = ADDR_W'(DEF_OFFSET),
  parameter int                RD_LAT = 1,
  parameter int                ERR_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W:0]    count,
  uram_chk_mem_if.master     mem,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [ADDR_W-1:0]  first_err_addr,
  output logic [DATA_W-1:0]  first_err_data
);

  state_t            state_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_ren_q;
  logic [ADDR_W:0]   remaining_q;
  logic              busy_q, done_q, pass_q;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_addr_q;
  logic [DATA_W-1:0] first_err_data_q;

  logic              chk_valid, pending;
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] expected;
  logic              mismatch, stop_issue;

  uram_chk_tag_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_tag_pipe (
    .clock     (clock),
    .reset     (reset),
    .valid_i   (mem_ren_q),
    .addr_i    (mem_addr_q),
    .valid_o   (chk_valid),
    .addr_o    (chk_addr),
    .pending_o (pending)
  );

  assign expected = DATA_W'(expected_word(32'(chk_addr), 32'(OFFSET), ADDR_W));
  assign mismatch = chk_valid && (mem.mem_rdata != expected);

  always_comb begin
    err_count_d = err_count_q;
    if (mismatch && (err_count_q != '1)) err_count_d = err_count_q + ERR_W'(1);
    stop_issue = 1'b0;
`ifdef URAM_CHK_STOP_ON_ERR_EN
    stop_issue = mismatch && (err_count_q == '0);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      mem_addr_q       <= '0;
      mem_ren_q        <= 1'b0;
      remaining_q      <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      first_err_data_q <= '0;
    end else begin
      err_count_q <= err_count_d;
      if (mismatch && (err_count_q == '0)) begin
        first_err_addr_q <= chk_addr;
        first_err_data_q <= mem.mem_rdata;
      end
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
            mem_addr_q       <= base_addr;
            remaining_q      <= count;
            if (count == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q   <= ISSUE;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              pass_q    <= 1'b0;
              mem_ren_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if ((remaining_q == (ADDR_W+1)'(1)) || stop_issue) begin
            mem_ren_q <= 1'b0;
            state_q   <= DRAIN;
          end else begin
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - (ADDR_W+1)'(1);
          end
        end
        DRAIN: begin
          // The last in-flight compare lands on this same edge, so pass
          // is taken from the next-state counter.
          if (!pending) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_d == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_ren    = mem_ren_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_data = first_err_data_q;

endmodule

`default_nettype wire

// File: tb/tb_uram_readback_checker.sv
// ------------------------------------------------------------------------
// tb_uram_readback_checker: directed bench, RD_LAT=1 and RD_LAT=3 instances.
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_uram_readback_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [11:0] base1 = '0, base2 = '0;
  logic [12:0] cnt1 = '0, cnt2 = '0;
  logic        busy1, done1, pass1, busy2, done2, pass2;
  logic [15:0] err1;
  logic [1:0]  err2;
  logic [11:0] fea1, fea2;
  logic [63:0] fed1, fed2;

  logic [63:0] mem [4096];
  logic [63:0] d1, d2;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [11:0] alog [$];
  int          lat, nren;

  uram_chk_mem_if #(.ADDR_W(12), .DATA_W(64)) mif1 ();
  uram_chk_mem_if #(.ADDR_W(12), .DATA_W(64)) mif2 ();

  uram_readback_checker #(.RD_LAT(1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .base_addr(base1), .count(cnt1),
    .mem(mif1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_addr(fea1), .first_err_data(fed1)
  );

  uram_readback_checker #(.RD_LAT(3), .ERR_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .start(start2), .base_addr(base2), .count(cnt2),
    .mem(mif2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_addr(fea2), .first_err_data(fed2)
  );

  always #5 clock = ~clock;

  // Behavioural URAMs: 1-cycle and 3-cycle read latency.
  always @(posedge clock) if (mif1.mem_ren) mif1.mem_rdata <= mem[mif1.mem_addr];
  always @(posedge clock) begin
    d1 <= mem[mif2.mem_addr];
    d2 <= d1;
    mif2.mem_rdata <= d2;
  end

  function automatic logic [63:0] pat(input int a);
    return 64'((a + 16) % 4096);
  endfunction

  task automatic sweep(input int which, input logic [11:0] base, input logic [12:0] cnt,
                       input int poke);
    logic r;
    alog.delete(); lat = 0; nren = 0;
    @(negedge clock);
    if (which == 1) begin start1 = 1'b1; base1 = base; cnt1 = cnt; end
    else            begin start2 = 1'b1; base2 = base; cnt2 = cnt; end
    for (int c = 1; c <= 300; c++) begin
      @(posedge clock); #1;
      start1 = 1'b0; start2 = 1'b0;
      if (c == poke) begin
        if (which == 1) begin start1 = 1'b1; base1 = 12'h000; end
        else            begin start2 = 1'b1; base2 = 12'h000; end
      end
      r = (which == 1) ? mif1.mem_ren : mif2.mem_ren;
      if (r) begin
        nren++;
        alog.push_back((which == 1) ? mif1.mem_addr : mif2.mem_addr);
      end
      if ((which == 1) ? done1 : done2) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy1); end
    n_vec++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done1); end
    n_vec++; if (pass1 !== 1'b0) begin n_bad++; $display("FAIL rst_pass got %b want 0", pass1); end
    n_vec++; if (err1 !== 16'd0) begin n_bad++; $display("FAIL rst_err got %h want 0", err1); end
    n_vec++; if ({fea1, fed1} !== 76'd0) begin n_bad++; $display("FAIL rst_first got %h/%h want 0", fea1, fed1); end
    n_vec++; if ({mif1.mem_ren, mif1.mem_addr} !== 13'd0) begin n_bad++; $display("FAIL rst_mem got %b/%h want 0", mif1.mem_ren, mif1.mem_addr); end
    n_vec++; if ({busy2, done2, pass2, err2, fea2, fed2, mif2.mem_ren, mif2.mem_addr} !== 94'd0) begin
      n_bad++; $display("FAIL rst_dut2 got %b%b%b %h %h %h want all 0", busy2, done2, pass2, err2, fea2, fed2); end
    reset = 1'b0;
  endtask

  task automatic test_sweep();
    sweep(1, 12'h000, 13'd8, 0);
    n_vec++; if (nren !== 8) begin n_bad++; $display("FAIL sweep_nren got %0d want 8", nren); end
    for (int i = 0; i < alog.size(); i++) begin
      n_vec++; if (alog[i] !== 12'(i)) begin n_bad++; $display("FAIL sweep_addr%0d got %h want %h", i, alog[i], 12'(i)); end
    end
    n_vec++; if (lat !== 10) begin n_bad++; $display("FAIL sweep_lat got %0d want 10", lat); end
    n_vec++; if ({done1, pass1, busy1} !== 3'b110) begin n_bad++; $display("FAIL sweep_flags got %b want 110", {done1, pass1, busy1}); end
    n_vec++; if (err1 !== 16'd0) begin n_bad++; $display("FAIL sweep_err got %0d want 0", err1); end
  endtask

  task automatic test_mismatch();
    int exp_n;
`ifdef URAM_CHK_STOP_ON_ERR_EN
    exp_n = 5;
`else
    exp_n = 8;
`endif
    mem[3] = 64'hDEAD;
    sweep(1, 12'h000, 13'd8, 0);
    n_vec++; if (err1 !== 16'd1) begin n_bad++; $display("FAIL mis_err got %0d want 1", err1); end
    n_vec++; if (fea1 !== 12'h003) begin n_bad++; $display("FAIL mis_addr got %h want 003", fea1); end
    n_vec++; if (fed1 !== 64'hDEAD) begin n_bad++; $display("FAIL mis_data got %h want dead", fed1); end
    n_vec++; if ({done1, pass1} !== 2'b10) begin n_bad++; $display("FAIL mis_pass got %b want 10", {done1, pass1}); end
    n_vec++; if (nren !== exp_n) begin n_bad++; $display("FAIL mis_nren got %0d want %0d", nren, exp_n); end
    mem[3] = pat(3);
  endtask

  task automatic test_wrap();
    logic [11:0] exp_a [4];
    exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
    sweep(1, 12'hFFE, 13'd4, 0);
    n_vec++; if (nren !== 4) begin n_bad++; $display("FAIL wrap_nren got %0d want 4", nren); end
    for (int i = 0; i < 4 && i < alog.size(); i++) begin
      n_vec++; if (alog[i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_addr%0d got %h want %h", i, alog[i], exp_a[i]); end
    end
    n_vec++; if ({done1, pass1, err1} !== {2'b11, 16'd0}) begin n_bad++; $display("FAIL wrap_pass got %b%b %0d want 11 0", done1, pass1, err1); end
  endtask

  task automatic test_count_zero();
    sweep(1, 12'h123, 13'd0, 0);
    n_vec++; if (nren !== 0) begin n_bad++; $display("FAIL zero_nren got %0d want 0", nren); end
    n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL zero_lat got %0d want 1", lat); end
    n_vec++; if ({done1, pass1, busy1, err1} !== {3'b110, 16'd0}) begin n_bad++; $display("FAIL zero_flags got %b%b%b %0d want 110 0", done1, pass1, busy1, err1); end
  endtask

  task automatic test_restart_ignored();
    int exp_n, exp_lat;
`ifdef URAM_CHK_STOP_ON_ERR_EN
    exp_n = 4; exp_lat = 6;
`else
    exp_n = 8; exp_lat = 10;
`endif
    mem[12'h102] = 64'hBEEF;
    sweep(1, 12'h100, 13'd8, 3);
    n_vec++; if (nren !== exp_n) begin n_bad++; $display("FAIL rs_nren got %0d want %0d", nren, exp_n); end
    n_vec++; if (alog.size() == 0 || alog[alog.size()-1] !== 12'(12'h100 + exp_n - 1)) begin
      n_bad++; $display("FAIL rs_last got %h want %h", (alog.size() == 0) ? 12'hxxx : alog[alog.size()-1], 12'(12'h100 + exp_n - 1)); end
    n_vec++; if (lat !== exp_lat) begin n_bad++; $display("FAIL rs_lat got %0d want %0d", lat, exp_lat); end
    n_vec++; if ({err1, fea1, fed1} !== {16'd1, 12'h102, 64'hBEEF}) begin n_bad++; $display("FAIL rs_err got %0d %h %h want 1 102 beef", err1, fea1, fed1); end
    repeat (3) @(negedge clock);
    n_vec++; if ({done1, pass1, err1, fea1} !== {2'b10, 16'd1, 12'h102}) begin n_bad++; $display("FAIL rs_hold got %b%b %0d %h want 10 1 102", done1, pass1, err1, fea1); end
    mem[12'h102] = pat(12'h102);
  endtask

  task automatic test_rd_lat3();
    mem[12'h022] = 64'h1234;
    sweep(2, 12'h020, 13'd6, 0);
    n_vec++; if (lat !== 10) begin n_bad++; $display("FAIL l3_lat got %0d want 10", lat); end
    n_vec++; if (nren !== 6) begin n_bad++; $display("FAIL l3_nren got %0d want 6", nren); end
    n_vec++; if ({err2, fea2, fed2} !== {2'd1, 12'h022, 64'h1234}) begin n_bad++; $display("FAIL l3_err got %0d %h %h want 1 022 1234", err2, fea2, fed2); end
    n_vec++; if ({done2, pass2} !== 2'b10) begin n_bad++; $display("FAIL l3_pass got %b want 10", {done2, pass2}); end
    mem[12'h022] = pat(12'h022);
  endtask

  task automatic test_saturate();
    for (int a = 12'h040; a <= 12'h044; a++) mem[a] = pat(a) ^ 64'hFF00;
    sweep(2, 12'h040, 13'd5, 0);
    n_vec++; if (err2 !== 2'b11) begin n_bad++; $display("FAIL sat_err got %0d want 3", err2); end
    n_vec++; if ({fea2, fed2} !== {12'h040, 64'hFF50}) begin n_bad++; $display("FAIL sat_first got %h %h want 040 ff50", fea2, fed2); end
    n_vec++; if ({done2, pass2} !== 2'b10) begin n_bad++; $display("FAIL sat_pass got %b want 10", {done2, pass2}); end
    for (int a = 12'h040; a <= 12'h044; a++) mem[a] = pat(a);
  endtask

  task automatic test_reset_midsweep();
    for (int a = 0; a < 8; a++) mem[a] = 64'hBAD0 + 64'(a);
    @(negedge clock); start1 = 1'b1; base1 = 12'h000; cnt1 = 13'd8;
    @(negedge clock); start1 = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_vec++; if ({busy1, done1, pass1, err1, fea1, fed1, mif1.mem_ren, mif1.mem_addr} !== 108'd0) begin
      n_bad++; $display("FAIL mid_rst got %b%b%b %0d %h %h %b %h want all 0", busy1, done1, pass1, err1, fea1, fed1, mif1.mem_ren, mif1.mem_addr); end
    reset = 1'b0;
    repeat (6) @(negedge clock);
    n_vec++; if ({busy1, done1, err1, mif1.mem_ren} !== 19'd0) begin
      n_bad++; $display("FAIL mid_after got %b%b %0d %b want 0 0 0 0", busy1, done1, err1, mif1.mem_ren); end
    for (int a = 0; a < 8; a++) mem[a] = pat(a);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = pat(a);
    test_reset();
    test_sweep();
    test_mismatch();
    test_wrap();
    test_count_zero();
    test_restart_ignored();
    test_rd_lat3();
    test_saturate();
    test_reset_midsweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
